// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit host command frames,
// checks framing and CRC7, latches index/argument and answers with an
// R1-format frame after NCR idle cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line released, waiting for a start bit (cmd_in == 0)
// RECEIVE  | shifting the remaining 47 command bits, MSB first
// CHECK    | one cycle: framing, then CRC7 verdict; latch index/arg/status
// WAIT_NCR | NCR-1 cycles of turnaround before the response
// SEND     | 48 cycles shifting the response frame out on cmd_out
module sd_card_cmd_responder #(
  parameter int NCR     = 2,
  parameter int FRAME_W = 48
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        cmd_in,
  input  logic        resp_enable,
  input  logic [31:0] resp_status,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        cmd_valid,
  output logic        crc_err,
  output logic        frame_err,
  output logic        busy
);

  // One counter serves the receive bit count, the NCR gap and the send
  // count; it only widens if NCR is set beyond what 6 bits can hold.
  localparam int CNT_W = (NCR > 64) ? $clog2(NCR) : 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECEIVE,
    S_CHECK,
    S_WAIT_NCR,
    S_SEND
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [FRAME_W-1:0]   resp_q, resp_d;
  logic                 out_q, out_d;
  logic                 oe_q, oe_d;
  logic [5:0]           index_q, index_d;
  logic [31:0]          arg_q, arg_d;
  logic                 valid_q, valid_d;
  logic                 crc_err_q, crc_err_d;
  logic                 frame_err_q, frame_err_d;

  logic [6:0]           rx_crc;
  logic [6:0]           tx_crc;

  // Serial CRC7 (x^7 + x^3 + 1, init 0) over the 40 header+payload bits.
  function automatic logic [6:0] crc7_40(input logic [FRAME_W-9:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = FRAME_W - 9; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  assign rx_crc = crc7_40(frame_q[FRAME_W-1:8]);
  assign tx_crc = crc7_40({2'b00, frame_q[45:40], resp_status});

  // Next-state and next-value logic for the whole receive/respond sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    resp_d      = resp_q;
    out_d       = 1'b1;
    oe_d        = 1'b0;
    index_d     = index_q;
    arg_d       = arg_q;
    valid_d     = 1'b0;
    crc_err_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!cmd_in) begin
          frame_d = {frame_q[FRAME_W-2:0], cmd_in};
          cnt_d   = CNT_W'(FRAME_W - 2);
          state_d = S_RECEIVE;
        end
      end

      S_RECEIVE: begin
        frame_d = {frame_q[FRAME_W-2:0], cmd_in};
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_CHECK: begin
        state_d = S_IDLE;
        // Framing wins over CRC so a garbled frame reports only one error.
        if (!frame_q[FRAME_W-2] || !frame_q[0]) begin
          frame_err_d = 1'b1;
        end else if (rx_crc != frame_q[7:1]) begin
          crc_err_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          index_d = frame_q[45:40];
          arg_d   = frame_q[39:8];
          resp_d  = {2'b00, frame_q[45:40], resp_status, tx_crc, 1'b1};
          if (resp_enable && (frame_q[45:40] != 6'd0)) begin
            cnt_d   = CNT_W'(NCR - 2);
            state_d = S_WAIT_NCR;
          end
        end
      end

      S_WAIT_NCR: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(FRAME_W - 1);
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_SEND: begin
        // Outputs are registered, so the line follows this state by a cycle.
        oe_d   = 1'b1;
        out_d  = resp_q[FRAME_W-1];
        resp_d = {resp_q[FRAME_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sd_clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      resp_q      <= '0;
      out_q       <= 1'b1;
      oe_q        <= 1'b0;
      index_q     <= '0;
      arg_q       <= '0;
      valid_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      resp_q      <= resp_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      index_q     <= index_d;
      arg_q       <= arg_d;
      valid_q     <= valid_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cmd_out   = out_q;
  assign cmd_oe    = oe_q;
  assign cmd_index = index_q;
  assign cmd_arg   = arg_q;
  assign cmd_valid = valid_q;
  assign crc_err   = crc_err_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
